// File: rtl/ziggurat_accept_ctrl_pkg.sv
// Shared widths, saturation constant and candidate record for the Ziggurat accept controller.
package ziggurat_accept_ctrl_pkg;
   localparam int UQ_W = 32;
   localparam int SQ_W = 32;
   localparam logic [SQ_W-1:0] SAT_POS = 32'h7FFF_FFFF;

   typedef logic [SQ_W-1:0] sample_t;

   typedef struct packed {
      logic [UQ_W-1:0] abs;
      logic [UQ_W-1:0] bound;
      logic            sign;
      logic            fast;
   } cand_t;

   // UQ4.28 magnitudes >= 8.0 do not fit SQ3.28 and clip to the largest positive value.
   function automatic sample_t to_signed(input logic [UQ_W-1:0] abs, input logic sign);
      sample_t mag;
      mag = abs[UQ_W-1] ? SAT_POS : sample_t'(abs);
      return sign ? -mag : mag;
   endfunction
endpackage

// File: rtl/ziggurat_accept_ctrl_if.sv
// Candidate input stream and sample output stream of the Ziggurat accept controller.
interface ziggurat_accept_ctrl_if;
   import ziggurat_accept_ctrl_pkg::*;

   logic            cand_valid;
   logic            cand_ready;
   logic [UQ_W-1:0] cand_abs;
   logic            cand_sign;
   logic            cand_fast;
   logic [UQ_W-1:0] cand_wedge_bound_ratio;
   logic            out_valid;
   logic            out_ready;
   sample_t         out_sample;

   modport master (
      output cand_valid, cand_abs, cand_sign, cand_fast, cand_wedge_bound_ratio, out_ready,
      input  cand_ready, out_valid, out_sample
   );

   modport slave (
      input  cand_valid, cand_abs, cand_sign, cand_fast, cand_wedge_bound_ratio, out_ready,
      output cand_ready, out_valid, out_sample
   );
endinterface

// File: rtl/ziggurat_accept_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; count is exported so the parent can issue credits.
module grng_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign do_pop  = pop & (cnt != '0);
   assign do_push = push & (cnt != (AW+1)'(DEPTH));
   assign dout    = mem[rd_ptr];
   assign valid   = (cnt != '0);
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/ziggurat_accept_ctrl.sv
// Ziggurat accept/reject stage: drives the external wedge Compare, signs/saturates accepted samples.
// Optional GRNG_STATS_EN adds saturating accept/reject counters with a stat_clr input.
module ziggurat_accept_ctrl
   import ziggurat_accept_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_REJECT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ziggurat_accept_ctrl_if.slave  cif,
   output logic [UQ_W-1:0]        cmp_abs_value,
   output logic [UQ_W-1:0]        cmp_wedge_bound_ratio,
   input  logic                   cmp_value,
   output logic                   rej_err
`ifdef GRNG_STATS_EN
  ,input  logic                   stat_clr,
   output logic [31:0]            stat_accept,
   output logic [31:0]            stat_reject
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = $clog2(MAX_REJECT + 1);

   cand_t         slot;
   logic          inflight;
   logic [CW-1:0] fifo_cnt;
   logic [CW:0]   used;
   logic [RW-1:0] consec_rej;
   logic          take, accept, reject;
   sample_t       fifo_dout;

   // A slot is reserved for the in-flight candidate so an accept can always be pushed.
   assign used           = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
   assign cif.cand_ready = rst_n & (used < (CW+1)'(FIFO_DEPTH));
   assign take           = cif.cand_valid & cif.cand_ready;

   assign accept = inflight & (slot.fast | cmp_value);
   assign reject = inflight & ~slot.fast & ~cmp_value;

   assign cmp_abs_value         = slot.abs;
   assign cmp_wedge_bound_ratio = slot.bound;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot       <= '0;
         inflight   <= 1'b0;
         consec_rej <= '0;
         rej_err    <= 1'b0;
      end else begin
         inflight <= take;
         if (take) begin
            slot.abs   <= cif.cand_abs;
            slot.bound <= cif.cand_wedge_bound_ratio;
            slot.sign  <= cif.cand_sign;
            slot.fast  <= cif.cand_fast;
         end
         if (accept) begin
            consec_rej <= '0;
         end else if (reject) begin
            if (consec_rej != RW'(MAX_REJECT)) consec_rej <= consec_rej + 1'b1;
            if (consec_rej >= RW'(MAX_REJECT - 1)) rej_err <= 1'b1;
         end
      end
   end

   grng_sync_fifo #(.WIDTH(SQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .din   (to_signed(slot.abs, slot.sign)),
      .pop   (cif.out_ready),
      .dout  (fifo_dout),
      .valid (cif.out_valid),
      .count (fifo_cnt)
   );

   // Uninitialised FIFO storage is never exposed.
   assign cif.out_sample = cif.out_valid ? fifo_dout : '0;

`ifdef GRNG_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         stat_accept <= '0;
         stat_reject <= '0;
      end else begin
         if (accept && stat_accept != '1) stat_accept <= stat_accept + 1'b1;
         if (reject && stat_reject != '1) stat_reject <= stat_reject + 1'b1;
      end
   end
`endif
endmodule
